spi_flash_responder: RTL and testbench

- SPI mode-0 flash responder: the FPGA presents itself as a read-only serial NOR flash to an external SPI master.
- Decodes READ (0x03), FAST_READ (0x0B), READ_JEDEC_ID (0x9F) and READ_STATUS (0x05).
- Fetches data bytes from an on-chip byte-wide memory port (BRAM) and shifts them out on MISO.
- SPI pins are sampled synchronously in the wb_clk_i domain; the system clock oversamples SCK.

---
 rtl/spi_flash_pkg.sv | 12 +
 rtl/spi_pin_sync.sv | 43 ++++
 rtl/spi_flash_responder.sv | 166 ++++++++++++++++
 tb/tb_spi_flash_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM encoding for the SPI NOR flash responder.
`timescale 1ns/1ps
package spi_flash_pkg;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_JEDEC     = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE
  } state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// Brings cs_n/sck/mosi into the system clock domain and derives SCK edge pulses.
`timescale 1ns/1ps
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic sck,
  input  logic mosi,
  output logic cs_n_s,
  output logic cs_fall,
  output logic sck_rise,
  output logic sck_fall,
  output logic mosi_s
);
  logic [SYNC_STAGES-1:0] cs_ff, sck_ff, mosi_ff;
  logic cs_prev, sck_prev;

  // The cs chain resets to "selected" so a cs_n already low at reset release
  // never looks like a fresh falling edge; a real high->low toggle is required.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_ff    <= '0;
      sck_ff   <= '0;
      mosi_ff  <= '0;
      cs_prev  <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      cs_ff    <= {cs_ff[SYNC_STAGES-2:0], cs_n};
      sck_ff   <= {sck_ff[SYNC_STAGES-2:0], sck};
      mosi_ff  <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      cs_prev  <= cs_ff[SYNC_STAGES-1];
      sck_prev <= sck_ff[SYNC_STAGES-1];
    end
  end

  assign cs_n_s   = cs_ff[SYNC_STAGES-1];
  assign mosi_s   = mosi_ff[SYNC_STAGES-1];
  assign cs_fall  = cs_prev & ~cs_n_s;
  assign sck_rise = ~sck_prev &  sck_ff[SYNC_STAGES-1] & ~cs_n_s;
  assign sck_fall =  sck_prev & ~sck_ff[SYNC_STAGES-1] & ~cs_n_s;
endmodule

// File: rtl/spi_flash_responder.sv
// Read-only SPI mode-0 NOR flash emulation backed by a byte-wide memory port.
`timescale 1ns/1ps
module spi_flash_responder import spi_flash_pkg::*; #(
  parameter int          ADDR_W      = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_spi_miso_oe,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [7:0]        i_mem_data,
  output logic              o_busy,
  output logic              o_underrun
);
  logic cs_n_s, cs_fall, sck_rise, sck_fall, mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .cs_n     (i_spi_cs_n),
    .sck      (i_spi_clk),
    .mosi     (i_spi_mosi),
    .cs_n_s   (cs_n_s),
    .cs_fall  (cs_fall),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .mosi_s   (mosi_s)
  );

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [7:0]  cmd_sh, cmd_byte, shift, pf_data, load_byte;
  logic [22:0] addr_sh;
  logic [23:0] addr_full;
  logic [1:0]  jidx;
  logic        pf_valid, pending, miso;
  logic        ack_now, load, mem_mode, addr_done, under_now;

  assign cmd_byte  = {cmd_sh[6:0], mosi_s};
  assign addr_full = {addr_sh, mosi_s};
  assign addr_done = (state == ST_ADDR) && sck_rise && (cnt == 5'd23);
  assign mem_mode  = (cmd_sh == OP_READ) || (cmd_sh == OP_FAST_READ);
  // A byte boundary in the data phase: every 8th falling edge, starting with the first.
  assign load      = (state == ST_DATA) && sck_fall && (cnt[2:0] == 3'd0);
  assign ack_now   = i_mem_ack && pending;
  assign o_spi_miso = miso;

  always_comb begin
    load_byte = 8'hFF;
    under_now = 1'b0;
    case (cmd_sh)
      OP_JEDEC: begin
        case (jidx)
          2'd0:    load_byte = JEDEC_ID[23:16];
          2'd1:    load_byte = JEDEC_ID[15:8];
          default: load_byte = JEDEC_ID[7:0];
        endcase
      end
      OP_RDSR: load_byte = 8'h00;
      default: begin
        if (ack_now)       load_byte = i_mem_data;
        else if (pf_valid) load_byte = pf_data;
        else               under_now = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_nxt     = state;
    o_spi_miso_oe = (state != ST_IDLE) && !cs_n_s;
    o_busy        = (state != ST_IDLE) && !cs_n_s;
    if (cs_n_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
        ST_CMD: begin
          if (sck_rise && cnt == 5'd7) begin
            case (cmd_byte)
              OP_READ, OP_FAST_READ: state_nxt = ST_ADDR;
              OP_JEDEC, OP_RDSR:     state_nxt = ST_DATA;
              default:               state_nxt = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR:  if (addr_done) state_nxt = (cmd_sh == OP_FAST_READ) ? ST_DUMMY : ST_DATA;
        ST_DUMMY: if (sck_rise && cnt == 5'd7) state_nxt = ST_DATA;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt        <= '0;
      cmd_sh     <= '0;
      addr_sh    <= '0;
      shift      <= '0;
      pf_data    <= '0;
      pf_valid   <= 1'b0;
      pending    <= 1'b0;
      jidx       <= '0;
      miso       <= 1'b1;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_underrun <= 1'b0;
    end else begin
      o_mem_req <= 1'b0;
      if (cs_n_s || state_nxt != state)
        cnt <= '0;
      else if ((sck_rise && (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY)) ||
               (sck_fall && state == ST_DATA))
        cnt <= cnt + 5'd1;

      if (state == ST_CMD && sck_rise)  cmd_sh  <= cmd_byte;
      if (state == ST_ADDR && sck_rise) addr_sh <= addr_full[22:0];
      if (addr_done) begin
        o_mem_req  <= 1'b1;
        o_mem_addr <= addr_full[ADDR_W-1:0];
      end

      if (ack_now) begin
        pf_data  <= i_mem_data;
        pf_valid <= 1'b1;
        pending  <= 1'b0;
      end

      if (state != ST_DATA) begin
        miso <= 1'b1;
      end else if (load) begin
        miso  <= load_byte[7];
        shift <= {load_byte[6:0], 1'b0};
        if (under_now) o_underrun <= 1'b1;
        if (cmd_sh == OP_JEDEC) jidx <= (jidx == 2'd2) ? 2'd0 : jidx + 2'd1;
        // Fetch the next byte now so it has a whole byte time to arrive.
        if (mem_mode) begin
          pf_valid   <= 1'b0;
          o_mem_req  <= 1'b1;
          o_mem_addr <= o_mem_addr + ADDR_W'(1);
        end
      end else if (sck_fall) begin
        miso  <= shift[7];
        shift <= {shift[6:0], 1'b0};
      end

      if (addr_done || (load && mem_mode)) pending <= 1'b1;
      if (cs_n_s) begin
        pending  <= 1'b0;
        pf_valid <= 1'b0;
        jidx     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Drives the flash responder as an SPI master and checks against a flash behaviour model.
`timescale 1ns/1ps
module tb_spi_flash_responder;
  localparam int HALF = 10;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        i_spi_cs_n = 1'b1, i_spi_clk = 1'b0, i_spi_mosi = 1'b0;
  logic        i_mem_ack = 1'b0;
  logic [7:0]  i_mem_data = 8'h00;
  logic        o_spi_miso, o_spi_miso_oe, o_mem_req, o_busy, o_underrun;
  logic [23:0] o_mem_addr;

  int checks = 0, errors = 0;
  logic [7:0]  mem [int unsigned];
  logic [7:0]  tx_q[$], rx_q[$], exp_q[$];
  logic [23:0] req_q[$], expa_q[$];
  int          drop_req = -1, req_n = 0, ack_dly = -1;
  logic [7:0]  ack_dat = 8'h00;
  bit          oe_bad, busy_bad;

  spi_flash_responder dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .i_spi_cs_n    (i_spi_cs_n),
    .i_spi_clk     (i_spi_clk),
    .i_spi_mosi    (i_spi_mosi),
    .o_spi_miso    (o_spi_miso),
    .o_spi_miso_oe (o_spi_miso_oe),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (i_mem_ack),
    .i_mem_data    (i_mem_data),
    .o_busy        (o_busy),
    .o_underrun    (o_underrun)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  // Memory port: answer each request 1 or 2 cycles later, except a chosen one.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      i_mem_ack = 1'b0;
      if (o_mem_req === 1'b1) begin
        req_q.push_back(o_mem_addr);
        if (req_n != drop_req) begin
          ack_dly = $urandom_range(0, 1);
          ack_dat = mem_rd(o_mem_addr);
        end
        req_n++;
      end
      if (ack_dly == 0) begin
        i_mem_ack  = 1'b1;
        i_mem_data = ack_dat;
      end
      if (ack_dly >= 0) ack_dly--;
    end
  end

  // Mode-0 master. The final bit leaves SCK high and cs_n rises first, so the
  // slave never sees a trailing falling edge that would start another byte.
  task automatic spi_xfer(input int nbits, input bit keep_cs);
    logic [7:0] cur, r;
    int total;
    total = (nbits < 0) ? 8 * tx_q.size() : nbits;
    rx_q.delete();
    oe_bad = 0; busy_bad = 0; r = '0;
    i_spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int k = 0; k < total; k++) begin
      cur = tx_q[k / 8];
      i_spi_mosi = cur[7 - (k % 8)];
      wait_clk(HALF);
      i_spi_clk = 1'b1;
      r = {r[6:0], o_spi_miso};
      if (o_spi_miso_oe !== 1'b1) oe_bad = 1;
      if (o_busy !== 1'b1) busy_bad = 1;
      if (k % 8 == 7) rx_q.push_back(r);
      wait_clk(HALF);
      if (k != total - 1) i_spi_clk = 1'b0;
    end
    if (!keep_cs) begin
      i_spi_cs_n = 1'b1;
      wait_clk(HALF);
    end
    i_spi_clk = 1'b0;
    wait_clk(2 * HALF);
  endtask

  task automatic run_op(input string tag, input logic [7:0] op, input logic [23:0] a,
                        input int nd, input int drop);
    int hdr;
    logic [23:0] id;
    bit is_mem;
    id = 24'hEF4016;
    is_mem = (op == 8'h03 || op == 8'h0B);
    tx_q.delete(); exp_q.delete(); expa_q.delete(); req_q.delete();
    req_n = 0; drop_req = drop;
    tx_q.push_back(op);
    hdr = 1;
    if (is_mem) begin
      tx_q.push_back(a[23:16]); tx_q.push_back(a[15:8]); tx_q.push_back(a[7:0]);
      hdr = 4;
      if (op == 8'h0B) begin tx_q.push_back(8'($urandom)); hdr = 5; end
    end
    for (int i = 0; i < nd; i++) tx_q.push_back(8'($urandom));
    for (int i = 0; i < hdr; i++) exp_q.push_back(8'hFF);
    for (int i = 0; i < nd; i++) begin
      if (is_mem)             exp_q.push_back((i == drop) ? 8'hFF : mem_rd(a + 24'(i)));
      else if (op == 8'h9F)   exp_q.push_back(8'(id >> (8 * (2 - (i % 3)))));
      else if (op == 8'h05)   exp_q.push_back(8'h00);
      else                    exp_q.push_back(8'hFF);
    end
    if (is_mem) for (int i = 0; i <= nd; i++) expa_q.push_back(a + 24'(i));
    spi_xfer(-1, 1'b0);
    chk($sformatf("%s rx_count", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s rx%0d", tag, i), rx_q[i], exp_q[i]);
    chk($sformatf("%s oe_bad", tag), oe_bad, 0);
    chk($sformatf("%s busy_bad", tag), busy_bad, 0);
    chk($sformatf("%s req_count", tag), req_q.size(), expa_q.size());
    for (int i = 0; i < expa_q.size() && i < req_q.size(); i++)
      chk($sformatf("%s req%0d", tag, i), req_q[i], expa_q[i]);
    chk($sformatf("%s oe_idle", tag), o_spi_miso_oe, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " miso"}, o_spi_miso, 1);
    chk({tag, " oe"}, o_spi_miso_oe, 0);
    chk({tag, " req"}, o_mem_req, 0);
    chk({tag, " addr"}, o_mem_addr, 0);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " underrun"}, o_underrun, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ops [5];
    logic [7:0] op;
    int n0;
    bit act_bad;
    for (int i = 0; i < 4; i++) mem[32'h100 + i] = 8'hA0 + 8'(i);
    mem[32'h10] = 8'h5A; mem[32'h11] = 8'hC3;
    mem[32'hFFFFFF] = 8'h77; mem[32'h0] = 8'h88;

    wait_clk(4);
    wb_rst_i = 1'b0;
    wait_clk(1);
    chk_reset_outs("reset");

    run_op("read", 8'h03, 24'h000100, 4, -1);
    run_op("fast", 8'h0B, 24'h000010, 2, -1);
    run_op("jedec", 8'h9F, 24'h0, 4, -1);
    run_op("rdsr", 8'h05, 24'h0, 2, -1);
    run_op("ignore", 8'hAB, 24'h0, 2, -1);
    run_op("wrap", 8'h03, 24'hFFFFFF, 2, -1);
    chk("underrun_clean", o_underrun, 0);
    run_op("underrun", 8'h03, 24'h002000, 3, 1);
    chk("underrun_set", o_underrun, 1);

    tx_q.delete();
    tx_q.push_back(8'h03); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    req_q.delete();
    spi_xfer(8 + 12, 1'b0);
    chk("abort req_count", req_q.size(), 0);
    run_op("restart", 8'h03, 24'h000000, 3, -1);
    chk("underrun_sticky", o_underrun, 1);

    ops = '{8'h03, 8'h0B, 8'h9F, 8'h05, 8'h00};
    for (int t = 0; t < 8; t++) begin
      op = ops[$urandom_range(0, 4)];
      if (op == 8'h00) op = 8'($urandom);
      run_op($sformatf("rnd%0d", t), op, 24'($urandom), $urandom_range(1, 4), -1);
      chk($sformatf("rnd%0d underrun", t), o_underrun, 1);
    end

    tx_q.delete();
    tx_q.push_back(8'h03); tx_q.push_back(8'h00); tx_q.push_back(8'h03); tx_q.push_back(8'h00);
    tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    spi_xfer(32 + 12, 1'b1);
    wb_rst_i = 1'b1;
    wait_clk(2);
    wb_rst_i = 1'b0;
    wait_clk(1);
    chk_reset_outs("midrst");
    n0 = req_q.size();
    act_bad = 0;
    for (int k = 0; k < 16; k++) begin
      wait_clk(HALF); i_spi_clk = 1'b1;
      if (o_spi_miso !== 1'b1 || o_spi_miso_oe !== 1'b0 || o_busy !== 1'b0) act_bad = 1;
      wait_clk(HALF); i_spi_clk = 1'b0;
    end
    chk("midrst quiet", act_bad, 0);
    chk("midrst no_req", req_q.size(), n0);
    i_spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
    run_op("post_rst", 8'h03, 24'h000300, 2, -1);
    chk("post_rst underrun", o_underrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
